// File: rtl/fb_pkg.sv
// Shared constants, types and the word-address helper for the framebuffer line fetcher.
package fb_pkg;

    localparam int unsigned H_RES          = 640;
    localparam int unsigned V_RES          = 480;
    localparam int unsigned FB_WORD_W      = 32;
    localparam int unsigned WORDS_PER_LINE = H_RES / FB_WORD_W;

    typedef logic [FB_WORD_W-1:0] fb_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD0,
        LOAD
    } fetch_state_t;

    // Word w of line y lives at base + y*20 + w; wraps modulo 2^16.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [8:0]  line,
                                              input logic [4:0]  word);
        return base + 16'(line) * 16'(WORDS_PER_LINE) + 16'(word);
    endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// Two-bank line buffer: one synchronous write port, one synchronous single-bit read port.
module fb_line_buffer
    import fb_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [4:0]        wr_word,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [4:0]        rd_word,
    input  logic [4:0]        rd_bit,
    output logic              rd_data
);

    logic [WORD_W-1:0] mem [2][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_word] <= wr_data;
        end
    end

    // The read register doubles as the pixel output flop, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 1'b0;
        end else if (rd_en) begin
            rd_data <= mem[rd_bank][rd_word][rd_bit];
        end else begin
            rd_data <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_line_fetch.sv
// Double-buffered 1 bpp framebuffer line fetcher for 640x480 VGA.
// Define FB_MSB_FIRST_EN to make bit 31 of each word the leftmost pixel (default: bit 0).
module fb_line_fetch
    import fb_pkg::*;
#(
    parameter logic [15:0] FB_BASE = 16'h0000,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              CLOCK_50,
    input  logic              nReset,
    input  logic [9:0]        pixel_x,
    input  logic [8:0]        pixel_y,
    input  logic              VGA_VS,
    output logic              pixel,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              underrun
);

    localparam logic [4:0] LastWord = 5'(WORDS_PER_LINE - 1);
    localparam logic [8:0] LastLine = 9'(V_RES - 1);

    fetch_state_t state_q, state_d;
    logic [4:0]   word_q, word_d;
    logic [8:0]   line_q, line_d;
    logic         req_q, req_d;
    logic [15:0]  addr_q, addr_d;
    logic         gap_q, gap_d;
    logic         disp_q, disp_d;
    logic         underrun_q, underrun_d;
    logic [1:0]   full_q, full_d;
    logic         vs_q;
    logic [8:0]   py_q;

    logic         vs_fall;
    logic         y_evt;
    logic         fill_bank;
    logic         wr_en;
    logic [4:0]   rd_bit;

    assign vs_fall   = vs_q & ~VGA_VS;
    assign y_evt     = (pixel_y != py_q) && (pixel_y != 9'd0);
    // LOAD0 fills bank 0 while bank 0 is also the displayed bank.
    assign fill_bank = (state_q == LOAD0) ? 1'b0 : ~disp_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        line_d     = line_q;
        req_d      = req_q;
        addr_d     = addr_q;
        gap_d      = gap_q;
        disp_d     = disp_q;
        underrun_d = underrun_q;
        full_d     = full_q;
        wr_en      = 1'b0;

        if (vs_fall) begin
            state_d    = LOAD0;
            line_d     = 9'd0;
            word_d     = 5'd0;
            disp_d     = 1'b0;
            underrun_d = 1'b0;
            full_d     = 2'b00;
            req_d      = 1'b0;
            gap_d      = 1'b1;
        end else if (y_evt) begin
            disp_d = ~disp_q;
            if (state_q != IDLE) begin
                underrun_d = 1'b1;
            end
            req_d  = 1'b0;
            word_d = 5'd0;
            if (pixel_y < LastLine) begin
                state_d        = LOAD;
                line_d         = pixel_y + 9'd1;
                gap_d          = 1'b1;
                full_d[disp_q] = 1'b0;
            end else begin
                state_d = IDLE;
                gap_d   = 1'b0;
            end
        end else if (gap_q) begin
            // One idle request cycle separates any abort from the restarted fetch.
            gap_d  = 1'b0;
            req_d  = 1'b1;
            addr_d = word_addr(FB_BASE, line_q, word_q);
        end else if (req_q && mem_ack) begin
            wr_en = 1'b1;
            if (word_q == LastWord) begin
                full_d[fill_bank] = 1'b1;
                word_d            = 5'd0;
                if (state_q == LOAD0) begin
                    state_d = LOAD;
                    line_d  = 9'd1;
                    addr_d  = word_addr(FB_BASE, 9'd1, 5'd0);
                end else begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end else begin
                word_d = word_q + 5'd1;
                addr_d = word_addr(FB_BASE, line_q, word_q + 5'd1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            word_q     <= 5'd0;
            line_q     <= 9'd0;
            req_q      <= 1'b0;
            addr_q     <= 16'd0;
            gap_q      <= 1'b0;
            disp_q     <= 1'b0;
            underrun_q <= 1'b0;
            full_q     <= 2'b00;
            vs_q       <= 1'b0;
            py_q       <= 9'd0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            line_q     <= line_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            gap_q      <= gap_d;
            disp_q     <= disp_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            vs_q       <= VGA_VS;
            py_q       <= pixel_y;
        end
    end

`ifdef FB_MSB_FIRST_EN
    assign rd_bit = 5'd31 - pixel_x[4:0];
`else
    assign rd_bit = pixel_x[4:0];
`endif

    fb_line_buffer #(
        .WORD_W (WORD_W)
    ) u_line_buffer (
        .clk     (CLOCK_50),
        .rst_n   (nReset),
        .wr_en   (wr_en),
        .wr_bank (fill_bank),
        .wr_word (word_q),
        .wr_data (mem_rdata),
        .rd_en   (full_q[disp_q]),
        .rd_bank (disp_q),
        .rd_word (pixel_x[9:5]),
        .rd_bit  (rd_bit),
        .rd_data (pixel)
    );

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_fb_line_fetch.sv
// Scoreboard bench for fb_line_fetch: memory requests checked by a monitor, flags and pixels direct.
`timescale 1ns/1ps
module tb_fb_line_fetch;
    import fb_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        nReset;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        VGA_VS;
    logic        pixel;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    fb_word_t    mem_rdata;
    logic        underrun;

    fb_word_t    fbmem [0:1023];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          hs_count = 0;
    int          ack_wait = 0;
    int          wait_cnt = 0;

`ifdef FB_MSB_FIRST_EN
    localparam logic EXP_PX33 = 1'b0;
`else
    localparam logic EXP_PX33 = 1'b1;
`endif

    always #10 CLOCK_50 = ~CLOCK_50;

    fb_line_fetch #(
        .FB_BASE (16'h0000),
        .WORD_W  (32)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .nReset    (nReset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .VGA_VS    (VGA_VS),
        .pixel     (pixel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .underrun  (underrun)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Memory model: acks a pending request after ack_wait idle cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt >= ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fbmem[mem_addr[9:0]];
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every accepted handshake pops one expected address.
    always @(negedge CLOCK_50) begin
        if (nReset && mem_req && mem_ack) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_req: got addr %0h expected none", mem_addr);
            end else begin
                check("req_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(16'(i));
    endtask

    task automatic vs_pulse();
        @(posedge CLOCK_50);
        #1;
        VGA_VS = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        VGA_VS = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge CLOCK_50);
            k++;
        end
        #1;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_pixel(input string name, input logic [9:0] x, input logic exp);
        pixel_x = x;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check(name, 32'(pixel), 32'(exp));
    endtask

    task automatic idle_check(input string name, input int cycles);
        repeat (cycles) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check(name, 32'(mem_req), 32'd0);
    endtask

    initial begin
        logic [15:0] cap;
        int          start;
        int          k;

        for (int i = 0; i < 1024; i++) fbmem[i] = {16'(i), ~16'(i)};
        fbmem[0]  = 32'h8000_0001;
        fbmem[1]  = 32'h0000_0002;
        fbmem[20] = 32'hFFFF_FFFF;
        fbmem[40] = 32'hFFFF_FFFF;

        nReset  = 1'b0;
        VGA_VS  = 1'b1;
        pixel_x = 10'd0;
        pixel_y = 9'd0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(posedge CLOCK_50);
        #1;
        nReset = 1'b1;
        idle_check("idle_before_vs", 5);

        // Preload lines 0 and 1 with zero-wait acks.
        push_range(0, 39);
        vs_pulse();
        wait_drain("preload", 300);
        idle_check("preload_idle", 3);
        check("preload_underrun", 32'(underrun), 32'd0);

        // Readout of line 0, word 0 = 8000_0001, word 1 = 0000_0002.
        @(posedge CLOCK_50);
        #1;
        check_pixel("px0", 10'd0, 1'b1);
        check_pixel("px31", 10'd31, 1'b1);
        check_pixel("px1", 10'd1, 1'b0);
        check_pixel("px33", 10'd33, EXP_PX33);

        // Line advance: y=1 shows bank 1 (line 1) and fetches line 2.
        push_range(40, 59);
        pixel_y = 9'd1;
        wait_drain("line2", 300);
        check_pixel("disp_bank1_px1", 10'd1, 1'b1);
        check("advance_underrun", 32'(underrun), 32'd0);
        idle_check("line2_idle", 2);

        // Last line: no fetch beyond 479.
        pixel_y = 9'd479;
        idle_check("y479_no_req", 10);
        check("y479_underrun", 32'(underrun), 32'd0);

        // Underrun: slow memory, y steps 1->2 after two words of line 2.
        push_range(0, 39);
        vs_pulse();
        wait_drain("preload2", 300);
        pixel_y = 9'd0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        ack_wait = 30;
        push_range(40, 41);
        push_range(60, 79);
        start   = hs_count;
        pixel_y = 9'd1;
        k = 0;
        while (hs_count < start + 2 && k < 300) begin
            @(posedge CLOCK_50);
            k++;
        end
        check("two_slow_acks", 32'(hs_count - start), 32'd2);
        repeat (5) @(posedge CLOCK_50);
        #1;
        pixel_y = 9'd2;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("abort_drop", 32'(mem_req), 32'd0);
        @(negedge CLOCK_50);
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd60);
        cap = mem_addr;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLOCK_50);
            check("hold_stable", 32'({mem_ack, mem_req, mem_addr}), 32'({1'b0, 1'b1, cap}));
        end
        check("underrun_set", 32'(underrun), 32'd1);
        check_pixel("incomplete_px0", 10'd0, 1'b0);
        wait_drain("restart", 1500);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Reset during LOAD word 7 (address 27).
        ack_wait = 0;
        pixel_y  = 9'd0;
        push_range(0, 39);
        vs_pulse();
        k = 0;
        while (!(mem_req && mem_addr == 16'd27) && k < 200) begin
            @(posedge CLOCK_50);
            #1;
            k++;
        end
        check("reached_word7", 32'({mem_req, mem_addr}), 32'({1'b1, 16'd27}));
        check("vs_clears_underrun", 32'(underrun), 32'd0);
        nReset = 1'b0;
        @(negedge CLOCK_50);
        exp_q.delete();
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_pixel", 32'(pixel), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        nReset = 1'b1;
        idle_check("idle_after_midrst", 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
